// File: rtl/sw_accum_pkg.sv
// sw_accum_pkg: shared constants for the switch/key accumulator peripheral.
//   - Avalon word addresses of the four registers
//   - bit positions inside STATUS
//   - roles of the first two keys
//   - request bundle used internally by the register file
package sw_accum_pkg;

  localparam logic [1:0] ADDR_ACC    = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_EDGE   = 2'd2;
  localparam logic [1:0] ADDR_MASK   = 2'd3;

  // STATUS: bit0 sticky overflow, debounced key levels start at bit1
  localparam int STAT_OVF     = 0;
  localparam int STAT_KEY_LSB = 1;

  localparam int KEY_CLR = 0;
  localparam int KEY_ACC = 1;

  typedef struct packed {
    logic [1:0]  addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } avs_req_t;

endpackage

// File: rtl/sw_accum_if.sv
// sw_accum_if: Avalon-MM slave bus plus interrupt line of the accumulator.
//   avs_address/avs_read/avs_write/avs_writedata : master -> slave
//   avs_readdata (registered, 1-cycle latency), irq : slave -> master
interface sw_accum_if;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport master (output avs_address, avs_read, avs_write, avs_writedata,
                  input  avs_readdata, irq);
  modport slave  (input  avs_address, avs_read, avs_write, avs_writedata,
                  output avs_readdata, irq);
endinterface

// File: rtl/sw_accum_pio_key_debounce.sv
// key_debounce: one push-button channel.
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   raw_n                  : raw active-low button, asynchronous
//   level                  : debounced level (1 = released)
//   press                  : one-cycle pulse on a debounced 1->0 transition
// Two-flop synchroniser, then a counter that only runs while the synced
// level disagrees with the debounced one; DEBOUNCE_CYC consecutive
// disagreeing cycles commit the new level.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 50000
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYC);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_q <= 1'b1;
    end else begin
      sync    <= {sync[0], raw_n};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // high for the cycle after the debounced level falls
  assign press = level_q & ~level;

endmodule

// File: rtl/sw_accum_pio.sv
// sw_accum_pio: switch/key accumulator with Avalon-MM slave and interrupt.
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   sw_i                   : raw switches (asynchronous)
//   key_n_i                : raw active-low keys; key0 clears, key1 accumulates
//   led_o                  : accumulator value
//   avs                    : register bus (ACC, STATUS, EDGE, MASK) and irq
module sw_accum_pio
  import sw_accum_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int N_KEYS       = 2,
  parameter int DEBOUNCE_CYC = 50000,
  parameter int SAT_MODE     = 0
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] sw_i,
  input  logic [N_KEYS-1:0] key_n_i,
  output logic [DATA_W-1:0] led_o,
  sw_accum_if.slave         avs
);

  logic [1:0][DATA_W-1:0] sw_sync;
  logic [N_KEYS-1:0]      key_lvl, key_press;
  logic [N_KEYS-1:0]      edge_q, mask_q;
  logic [DATA_W-1:0]      acc, acc_n;
  logic                   ovf, ovf_n;
  logic [DATA_W:0]        sum;
  logic [31:0]            rd_mux;
  logic                   wr_acc, wr_stat, wr_edge, wr_mask;
  logic                   unused_wdata;
  avs_req_t               req;

  genvar k;
  generate
    for (k = 0; k < N_KEYS; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .raw_n         (key_n_i[k]),
        .level         (key_lvl[k]),
        .press         (key_press[k])
      );
    end
  endgenerate

  always_comb begin
    req.addr  = avs.avs_address;
    req.rd    = avs.avs_read;
    req.wr    = avs.avs_write;
    req.wdata = avs.avs_writedata;
  end

  assign wr_acc       = req.wr && (req.addr == ADDR_ACC);
  assign wr_stat      = req.wr && (req.addr == ADDR_STATUS);
  assign wr_edge      = req.wr && (req.addr == ADDR_EDGE);
  assign wr_mask      = req.wr && (req.addr == ADDR_MASK);
  assign unused_wdata = ^req.wdata;

  // clear beats a bus write to ACC, which beats accumulate
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, sw_sync[1]};
    acc_n = acc;
    ovf_n = ovf;
    if (key_press[KEY_CLR]) begin
      acc_n = '0;
      ovf_n = 1'b0;
    end else if (wr_acc) begin
      acc_n = req.wdata[DATA_W-1:0];
    end else begin
      if (key_press[KEY_ACC])
        acc_n = (SAT_MODE != 0 && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
      // a carry in the same cycle as a W1C keeps the flag set
      ovf_n = (ovf & ~(wr_stat & req.wdata[STAT_OVF])) | (key_press[KEY_ACC] & sum[DATA_W]);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_ACC:    rd_mux[DATA_W-1:0] = acc;
      ADDR_STATUS: begin
        rd_mux[STAT_OVF]                = ovf;
        rd_mux[STAT_KEY_LSB +: N_KEYS]  = key_lvl;
      end
      ADDR_EDGE:   rd_mux[N_KEYS-1:0] = edge_q;
      default:     rd_mux[N_KEYS-1:0] = mask_q;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_sync          <= '0;
      acc              <= '0;
      ovf              <= 1'b0;
      edge_q           <= '0;
      mask_q           <= '0;
      avs.avs_readdata <= '0;
      avs.irq          <= 1'b0;
    end else begin
      sw_sync <= {sw_sync[0], sw_i};
      acc     <= acc_n;
      ovf     <= ovf_n;
      // new press events win over a W1C of the same bit
      edge_q  <= (edge_q & ~(wr_edge ? req.wdata[N_KEYS-1:0] : '0)) | key_press;
      if (wr_mask) mask_q <= req.wdata[N_KEYS-1:0];
      if (req.rd)  avs.avs_readdata <= rd_mux;
      avs.irq <= |(edge_q & mask_q);
    end
  end

  assign led_o = acc;

endmodule

// File: tb/tb_sw_accum_pio.sv
module tb_sw_accum_pio;
  localparam int DW = 8, NK = 2, DB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic [DW-1:0] sw    = '0;
  logic [NK-1:0] key_n = '1;
  logic [1:0]    addr  = '0;
  logic          rd    = 1'b0, wr = 1'b0;
  logic [31:0]   wd    = '0;
  logic [DW-1:0] led_w, led_s;

  sw_accum_if bus_w();
  sw_accum_if bus_s();
  assign bus_w.avs_address = addr;  assign bus_s.avs_address = addr;
  assign bus_w.avs_read = rd;       assign bus_s.avs_read = rd;
  assign bus_w.avs_write = wr;      assign bus_s.avs_write = wr;
  assign bus_w.avs_writedata = wd;  assign bus_s.avs_writedata = wd;

  sw_accum_pio #(.DATA_W(DW), .N_KEYS(NK), .DEBOUNCE_CYC(DB), .SAT_MODE(0)) u_wrap (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_i(sw), .key_n_i(key_n), .led_o(led_w), .avs(bus_w.slave));
  sw_accum_pio #(.DATA_W(DW), .N_KEYS(NK), .DEBOUNCE_CYC(DB), .SAT_MODE(1)) u_sat (
    .clk_clk(clk), .reset_reset_n(rst_n), .sw_i(sw), .key_n_i(key_n), .led_o(led_s), .avs(bus_s.slave));

  int total = 0, bad = 0;

  // reference model; index 0 = wrapping instance, 1 = saturating instance
  logic [1:0][DW-1:0]   m_acc;
  logic [1:0]           m_ovf;
  logic [NK-1:0]        m_edge, m_mask, m_lvl, m_pend;
  logic [NK-1:0][DB+1:0] m_kh;   // raw key samples, bit0 = most recent edge
  logic [1:0][DW-1:0]   m_swh;   // raw switch samples, [0] = most recent edge
  logic [1:0][31:0]     m_rd;
  logic                 m_irq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model across the coming clock edge using the current inputs.
  task automatic model_step();
    logic [DW:0]   s;
    logic [NK-1:0] pr;
    logic [31:0]   rv;
    if (!rst_n) begin
      m_acc = '0; m_ovf = '0; m_edge = '0; m_mask = '0;
      m_lvl = '1; m_pend = '0; m_kh = '1; m_swh = '0; m_rd = '0; m_irq = 1'b0;
      return;
    end
    pr = m_pend;
    for (int j = 0; j < 2; j++) begin
      case (addr)
        2'd0:    rv = 32'(m_acc[j]);
        2'd1:    rv = 32'({m_lvl, m_ovf[j]});
        2'd2:    rv = 32'(m_edge);
        default: rv = 32'(m_mask);
      endcase
      if (rd) m_rd[j] = rv;
    end
    m_irq = |(m_edge & m_mask);
    for (int j = 0; j < 2; j++) begin
      // switches seen by the accumulator lag the pins by two edges
      s = {1'b0, m_acc[j]} + {1'b0, m_swh[1]};
      if (pr[0]) begin
        m_acc[j] = '0; m_ovf[j] = 1'b0;
      end else if (wr && addr == 2'd0) begin
        m_acc[j] = wd[DW-1:0];
      end else begin
        if (wr && addr == 2'd1 && wd[0]) m_ovf[j] = 1'b0;
        if (pr[1]) begin
          if (s[DW]) m_ovf[j] = 1'b1;
          m_acc[j] = (j == 1 && s[DW]) ? '1 : s[DW-1:0];
        end
      end
    end
    m_edge = (m_edge & ~((wr && addr == 2'd2) ? wd[NK-1:0] : '0)) | pr;
    if (wr && addr == 2'd3) m_mask = wd[NK-1:0];
    // a key level flips once its last DB synchronised samples all oppose it
    for (int k = 0; k < NK; k++) begin
      m_pend[k] = 1'b0;
      if (m_kh[k][DB:1] == {DB{~m_lvl[k]}}) begin
        m_lvl[k]  = ~m_lvl[k];
        m_pend[k] = ~m_lvl[k];
      end
      m_kh[k] = {m_kh[k][DB:0], key_n[k]};
    end
    m_swh[1] = m_swh[0];
    m_swh[0] = sw;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk); #1;
    chk("led_wrap", 32'(led_w), 32'(m_acc[0]));
    chk("led_sat", 32'(led_s), 32'(m_acc[1]));
    chk("irq_wrap", 32'(bus_w.irq), 32'(m_irq));
    chk("irq_sat", 32'(bus_s.irq), 32'(m_irq));
    chk("rdata_wrap", bus_w.avs_readdata, m_rd[0]);
    chk("rdata_sat", bus_s.avs_readdata, m_rd[1]);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    addr = a; wd = d; wr = 1'b1; tick(); wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    addr = a; rd = 1'b1; tick(); rd = 1'b0;
  endtask

  task automatic press(input int k, input int hold);
    key_n[k] = 1'b0; repeat (hold) tick();
    key_n[k] = 1'b1; repeat (10) tick();
  endtask

  typedef struct {
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{2'd0, 32'h0000_005A, 32'h5A};
    vt[1] = '{2'd0, 32'h0000_01FF, 32'hFF};
    vt[2] = '{2'd0, 32'hFFFF_FF00, 32'h00};
    vt[3] = '{2'd3, 32'hFFFF_FFFF, 32'h3};
    vt[4] = '{2'd3, 32'h0000_0001, 32'h1};
    vt[5] = '{2'd1, 32'hFFFF_FFFE, 32'h6};
    vt[6] = '{2'd2, 32'h0000_0000, 32'h0};
    vt[7] = '{2'd3, 32'h0000_0000, 32'h0};

    // 1: reset and accumulate latency
    repeat (3) tick();
    chk("rst_led", 32'(led_w), 32'h0);
    chk("rst_irq", 32'(bus_w.irq), 32'h0);
    chk("rst_rdata", bus_w.avs_readdata, 32'h0);
    rst_n = 1'b1; sw = 8'h05; repeat (3) tick();
    key_n[1] = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("acc_latency", 32'(led_w), (i == 7) ? 32'h05 : 32'h00);
    end
    repeat (3) tick(); key_n[1] = 1'b1; repeat (10) tick();
    press(1, 10);
    chk("acc_second", 32'(led_w), 32'h0A);
    bus_rd(2'd1); chk("status_no_ovf", bus_w.avs_readdata, 32'h6);
    bus_rd(2'd2); chk("edge_key1", bus_w.avs_readdata, 32'h2);
    bus_wr(2'd2, 32'h3);

    // 2: bounce rejection, then a real press
    repeat (5) begin
      key_n[1] = 1'b0; repeat (2) tick();
      key_n[1] = 1'b1; repeat (2) tick();
    end
    repeat (8) tick();
    chk("bounce_acc", 32'(led_w), 32'h0A);
    bus_rd(2'd2); chk("bounce_edge", bus_w.avs_readdata, 32'h0);
    key_n[1] = 1'b0; repeat (6) tick(); key_n[1] = 1'b1; repeat (10) tick();
    chk("hold6_acc", 32'(led_w), 32'h0F);
    bus_rd(2'd2); chk("hold6_edge", bus_w.avs_readdata, 32'h2);
    bus_wr(2'd2, 32'h3);

    // 3: wrap vs saturate
    bus_wr(2'd0, 32'hF0); sw = 8'h20; repeat (3) tick();
    press(1, 8);
    chk("wrap_acc", 32'(led_w), 32'h10);
    chk("sat_acc", 32'(led_s), 32'hFF);
    bus_rd(2'd1);
    chk("wrap_ovf", bus_w.avs_readdata, 32'h7);
    chk("sat_ovf", bus_s.avs_readdata, 32'h7);

    // 4: clear + accumulate + ACC write in one cycle -> clear wins
    key_n = 2'b00; repeat (6) tick();
    addr = 2'd0; wd = 32'h33; wr = 1'b1; tick(); wr = 1'b0;
    chk("prio_acc_wrap", 32'(led_w), 32'h0);
    chk("prio_acc_sat", 32'(led_s), 32'h0);
    repeat (2) tick(); key_n = 2'b11; repeat (10) tick();
    bus_rd(2'd1); chk("prio_ovf", bus_w.avs_readdata, 32'h6);

    // overflow flag W1C
    bus_wr(2'd0, 32'hF0); press(1, 8);
    bus_rd(2'd1); chk("ovf_set", bus_w.avs_readdata, 32'h7);
    bus_wr(2'd1, 32'h1);
    bus_rd(2'd1);
    chk("ovf_w1c_wrap", bus_w.avs_readdata, 32'h6);
    chk("ovf_w1c_sat", bus_s.avs_readdata, 32'h6);

    // 5: edge capture and interrupt
    bus_wr(2'd2, 32'h3); bus_wr(2'd3, 32'h2);
    press(0, 8);
    bus_rd(2'd2); chk("edge_k0", bus_w.avs_readdata, 32'h1);
    chk("irq_k0_masked", 32'(bus_w.irq), 32'h0);
    key_n[1] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) chk("irq_before", 32'(bus_w.irq), 32'h0);
      if (i == 8) chk("irq_after", 32'(bus_w.irq), 32'h1);
    end
    repeat (2) tick(); key_n[1] = 1'b1; repeat (10) tick();
    bus_rd(2'd2); chk("edge_k01", bus_w.avs_readdata, 32'h3);
    bus_wr(2'd2, 32'h2); chk("irq_hold", 32'(bus_w.irq), 32'h1);
    tick(); chk("irq_clear", 32'(bus_w.irq), 32'h0);
    bus_rd(2'd2); chk("edge_after_w1c", bus_w.avs_readdata, 32'h1);

    // 6: read timing and reset mid-debounce
    bus_rd(2'd0); chk("rd_acc", bus_w.avs_readdata, 32'h20);
    addr = 2'd3; repeat (3) tick();
    chk("rd_hold", bus_w.avs_readdata, 32'h20);
    key_n[1] = 1'b0; repeat (5) tick();
    rst_n = 1'b0; repeat (2) tick(); rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("rst_mid_debounce", 32'(led_w), (i == 7) ? 32'h20 : 32'h00);
    end
    key_n[1] = 1'b1; repeat (10) tick();

    // register read/write table
    bus_wr(2'd2, 32'h3); bus_wr(2'd1, 32'h1);
    for (int i = 0; i < 8; i++) begin
      bus_wr(vt[i].a, vt[i].d);
      bus_rd(vt[i].a);
      chk($sformatf("table%0d_wrap", i), bus_w.avs_readdata, vt[i].exp);
      chk($sformatf("table%0d_sat", i), bus_s.avs_readdata, vt[i].exp);
    end

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) key_n[0] = ~key_n[0];
      if ($urandom_range(0, 4) == 0)  key_n[1] = ~key_n[1];
      if ($urandom_range(0, 15) == 0) sw = DW'($urandom);
      rd    = ($urandom_range(0, 2) == 0);
      wr    = ($urandom_range(0, 5) == 0);
      addr  = 2'($urandom);
      wd    = $urandom;
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rd = 1'b0; wr = 1'b0; rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sw_accum_pio.md
Name: sw_accum_pio

Overview:
- Parametrised switch/key accumulator peripheral for the lab SoC.
- Sums the switch word into an accumulator on each debounced "accumulate" key press, clears it on each debounced "clear" key press, and drives the LEDs with the result.
- Generalises the fixed 8-bit accumulate/reset-button design: configurable width, key count, debounce time and overflow mode, plus a 4-word Avalon-MM slave with edge capture and an interrupt for the NIOS.

Parameters:
- DATA_W, 8, switch/accumulator/LED width (1..32).
- N_KEYS, 2, number of key inputs (>=2). Key0 = clear, key1 = accumulate, others are capture-only.
- DEBOUNCE_CYC, 50000, consecutive stable cycles required before a debounced level changes (>=2).
- SAT_MODE, 0, 0 = wrap modulo 2^DATA_W; 1 = saturate at all-ones.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous, active-low reset
- sw_i  in  DATA_W  raw switches, asynchronous
- key_n_i  in  N_KEYS  raw push-buttons, active-low, asynchronous
- led_o  out  DATA_W  accumulator value
- avs_address  in  2  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, registered
- irq  out  1  level interrupt

Behaviour:
- **Reset**, sampled on clk_clk while reset_reset_n = 0: acc = 0, ovf = 0, edge = 0, mask = 0, debounced keys = released (1), debounce counters = 0, synchroniser flops = 1 (keys) / 0 (sw), avs_readdata = 0, irq = 0, led_o = 0. Reset asserted mid-debounce discards the partial count.
- **Synchronisers:** two flops on every sw_i and key_n_i bit.
- **Debounce, per key:**
  - If the synced level equals the debounced level, the counter is 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYC-1 while the level still differs, the debounced level takes the synced value and the counter returns to 0.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no change.
- **Press event:** a debounced 1->0 transition, a one-cycle pulse. Release events are ignored.
- **Accumulator update (registered):** priority, highest first, within one cycle:
  1. key0 press -> acc = 0, ovf = 0.
  2. Avalon write to ACC -> acc = writedata[DATA_W-1:0]; ovf unchanged.
  3. key1 press -> sum = acc + synced sw, computed at DATA_W+1 bits.
     - If sum[DATA_W] = 1, set ovf (sticky).
     - SAT_MODE = 0: acc = sum[DATA_W-1:0].
     - SAT_MODE = 1: acc = all-ones on carry, else the sum.
- **Latency:**
  - Raw key edge to synced edge: 2 cycles.
  - Synced edge to debounced change: DEBOUNCE_CYC cycles.
  - Debounced change to acc/led_o update: 1 cycle.
- **led_o = acc** (direct from the register).
- **Register map** (word address, 32-bit, unused bits read 0):
  - 0 ACC: R/W, bits [DATA_W-1:0].
  - 1 STATUS: bit0 ovf (W1C); bits [N_KEYS:1] debounced key levels (RO).
  - 2 EDGE: bit k set on key k press event; W1C per bit. A press in the same cycle as a W1C of that bit leaves the bit set (set wins).
  - 3 MASK: R/W, bits [N_KEYS-1:0].
- **Read:** avs_readdata is valid the cycle after avs_read (fixed one-cycle read latency, no waitrequest) and holds its value until the next read.
- **Write:** takes effect at the clock edge where avs_write = 1.
- **Simultaneous read/write:** read returns pre-write contents.
- **Interrupt:** irq is registered; irq = |(edge & mask), so it updates one cycle after edge or mask changes.

Decomposition:
- **Shared package sw_accum_pkg:**
  - register address constants ADDR_ACC = 0, ADDR_STATUS = 1, ADDR_EDGE = 2, ADDR_MASK = 3;
  - STATUS bit index constants;
  - key index constants KEY_CLR = 0, KEY_ACC = 1.
- **Sub-module key_debounce:** one instance per key, generated.
  - Parameter DEBOUNCE_CYC.
  - Ports: clk_clk, reset_reset_n, raw_n, level, press.
  - Contains the 2-flop synchroniser, the stable counter and the falling-edge pulse.
- **Top level:** switch synchroniser, accumulator datapath, register file and irq.

Test Plan (DEBOUNCE_CYC = 4 for simulation):
1. **Reset/accumulate:** Reset 3 cycles. sw = 0x05, press key1 for 10 cycles -> led_o = 0x05 exactly 2+4+1 = 7 cycles after key1 falls. Press again -> 0x0A; ovf = 0.
2. **Bounce rejection:** key1 toggles low 2 cycles / high 2 cycles, repeated 5 times -> acc unchanged, EDGE = 0. Then held low 6 cycles -> exactly one accumulate.
3. **Wrap vs saturate:** acc = 0xF0 via Avalon write, sw = 0x20, key1 press.
   - SAT_MODE = 0 -> acc = 0x10, STATUS bit0 = 1.
   - SAT_MODE = 1 -> acc = 0xFF, STATUS bit0 = 1.
   - Writing 0x1 to STATUS -> ovf = 0.
4. **Priority:** key0 and key1 press events in the same cycle, with an Avalon write of 0x33 to ACC -> acc = 0, ovf = 0.
5. **Interrupt/edge:** MASK = 0x2, press key0 -> EDGE = 0x1, irq = 0. Press key1 -> EDGE = 0x3, irq = 1 one cycle after the edge bit sets. Write 0x2 to EDGE -> irq = 0 next cycle, EDGE = 0x1.
6. **Read timing/reset mid-debounce:**
   - Read addr 0 -> readdata = acc on the following cycle.
   - Assert reset with key1 held low for 3 of 4 debounce cycles, release reset, key still low -> the press registers only after a full fresh 2+4 cycles.
